// File: rtl/delay_line_pkg.sv
// Shared constants for the delay-line probe: FSM state codes
// and default marker/timeout values.
package delay_line_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FLUSH = 3'd1;
  localparam logic [2:0] SEND  = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [7:0] DEF_PATTERN  = 8'hA5;
  localparam int         DEF_MAX_WAIT = 255;

endpackage

// File: rtl/delay_line_probe.sv
// Delay-line latency probe: flushes the line, launches one marker
// word, counts cycles until it returns at echo_in, or times out.
//
// Ports:
//   clock     rising-edge clock
//   reset     synchronous active-high reset
//   start     request a measurement (sampled in IDLE only)
//   echo_in   output of the delay line under test
//   probe_out registered drive into the delay line
//   busy      measurement in progress
//   done      one-cycle result-valid pulse
//   latency   measured cycles, held until next accepted start
//   timeout   no echo seen within MAX_WAIT, held like latency
module delay_line_probe
  import delay_line_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] PATTERN  = WIDTH'(DEF_PATTERN),
  parameter int               MAX_WAIT = DEF_MAX_WAIT,
  parameter int               CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] echo_in,
  output logic [WIDTH-1:0] probe_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] latency,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] FL_LAST = CNT_W'(MAX_WAIT - 1);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] lat_d;
  logic             to_d;
  logic             hit;

  assign hit = (echo_in == PATTERN);

  // FLUSH and WAIT share cnt_q; a match in the same
  // cycle as counter==MAX_WAIT is reported as a hit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = latency;
    to_d    = timeout;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FLUSH;
          cnt_d   = '0;
          lat_d   = '0;
          to_d    = 1'b0;
        end
      end
      FLUSH: begin
        if (cnt_q == FL_LAST) begin
          state_d = SEND;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SEND: begin
        if (hit) begin
          state_d = DONE;
          lat_d   = '0;
          to_d    = 1'b0;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (hit) begin
          state_d = DONE;
          lat_d   = cnt_q;
          to_d    = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = DONE;
          lat_d   = CNT_MAX;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line
  // up with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      probe_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      latency   <= '0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      probe_out <= (state_d == SEND) ? PATTERN : '0;
      busy      <= (state_d == FLUSH) ||
                   (state_d == SEND)  ||
                   (state_d == WAIT);
      done      <= (state_d == DONE);
      latency   <= lat_d;
      timeout   <= to_d;
    end
  end

endmodule

// File: doc/delay_line_probe.md
Name: delay_line_probe

Overview:
- Measuring end of a delay-line path: launches a one-cycle marker word into a delay line and counts clock cycles until the marker reappears at the line output.
- Reports the measured latency, or a timeout.
- Sits beside the fixed delay lines so the top level can self-test and characterise whichever line is selected.
- Drives the line's data input and observes its output; no other coupling.

Parameters:
- WIDTH, 8, data width of the probe word and echo word.
- PATTERN, 8'hA5, marker word launched in SEND; must be nonzero.
- MAX_WAIT, 255, maximum counted latency before timeout; also the flush length.
- CNT_W, 8, width of the latency counter; must satisfy 2**CNT_W > MAX_WAIT.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a measurement; sampled only in IDLE.
- echo_in  in  WIDTH  output of the delay line under test.
- probe_out  out  WIDTH  registered; drives the delay line data input.
- busy  out  1  high from the cycle after start is accepted until the cycle done is asserted.
- done  out  1  one-cycle pulse when a result is valid.
- latency  out  CNT_W  measured cycles; held from done until the next accepted start.
- timeout  out  1  set with done when no echo arrived; held like latency.

Behaviour:
- Reset: state IDLE; probe_out=0, busy=0, done=0, latency=0, timeout=0, counter=0. Reset during any state aborts the measurement immediately with these values; no done pulse.
- Clocking: all outputs are registered.
- IDLE: probe_out=0. When start=1, go to FLUSH: clear counter, clear latency/timeout, set busy.
- FLUSH: probe_out=0 for exactly MAX_WAIT cycles to purge stale data; echo_in is ignored. Then go to SEND with counter=0.
- SEND (one cycle): probe_out=PATTERN.
  - If echo_in==PATTERN in this same cycle (zero-stage path), finish with latency=0.
  - Otherwise go to WAIT; counter becomes 1.
- WAIT: probe_out=0.
  - Each cycle, compare echo_in with PATTERN. On a match, latch latency=counter, timeout=0, go to DONE.
  - With no match and counter==MAX_WAIT, latch latency=MAX_WAIT, timeout=1, go to DONE.
  - Otherwise increment counter.
  - Latency definition: echo_in is sampled N rising edges after the edge that first presented PATTERN on probe_out, so a D-register line reports exactly D.
- DONE (one cycle): done=1, busy=0 in the same cycle, then return to IDLE. start asserted in DONE is ignored.
- start while busy: ignored, with no queueing.
- start held high in IDLE: a new measurement begins on each return to IDLE (back-to-back operation allowed).
- Only the first match counts; later echoes are ignored.
- Counter never wraps, because MAX_WAIT < 2**CNT_W.
- Simultaneous match and counter==MAX_WAIT: the match wins (timeout=0, latency=MAX_WAIT).

Decomposition:
- Shared package delay_line_pkg holds:
  - state encoding constants: IDLE, FLUSH, SEND, WAIT, DONE (3-bit).
  - the default PATTERN value.
  - the default MAX_WAIT value.
- Single module; the FSM and counter are inline, and no sub-module is warranted. The FLUSH and WAIT phases share one counter.

Test Plan:
- Reset check: assert reset for 3 cycles with start=1. Required: probe_out=0, busy=0, done=0, latency=0, timeout=0 throughout, and no measurement begins while reset is high.
- Nominal 60 stage: connect a 60-register shift-register model, pulse start. Required: busy high for the measurement, probe_out=8'hA5 for exactly one cycle, done pulse, latency=60, timeout=0.
- Zero stage: wire echo_in=probe_out. Required: latency=0, timeout=0. Then insert a 1-register path. Required: latency=1.
- Timeout: use a 300-register model, or tie echo_in=0. Required: done after MAX_WAIT counted cycles, latency=255, timeout=1.
- Dirty line and robustness:
  - Preload a 90-register model with 8'hA5 in every stage and start. Required: flush discards stale markers, latency=90.
  - Pulse start again mid-WAIT. Required: ignored, and the result is still 90.
- Reset mid-WAIT, then restart: assert reset 20 cycles after SEND. Required: outputs return to 0 and no done pulse. A subsequent start on a 45-register model gives latency=45.
